// File: rtl/mips_core_pkg.sv
// Shared MIPS core types and widths used by the data cache.
package mips_core_pkg;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 26;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_action_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } d_cache_state_t;

  // Tag field is full address width so any INDEX/OFFSET split fits.
  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [ADDR_WIDTH-1:0] tag;
  } d_cache_tag_t;
endpackage

// File: rtl/d_cache_data_array.sv
// Word-addressable flop array: one combinational read port, one write port.
module d_cache_data_array #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);
  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/d_cache_lite.sv
// Direct-mapped write-back write-allocate data cache with word-serial refill.
// Optional hit/miss counters when D_CACHE_STATS_EN is defined.
module d_cache_lite
  import mips_core_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH  = 4,
  parameter int unsigned OFFSET_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  input  logic                  i_in_mem_action,
  input  logic [ADDR_WIDTH-1:0] i_in_addr,
  input  logic [ADDR_WIDTH-1:0] i_in_addr_next,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef D_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int unsigned LINE_SHIFT = INDEX_WIDTH + OFFSET_WIDTH;
  localparam int unsigned NUM_LINES  = 32'd1 << INDEX_WIDTH;

  d_cache_state_t          state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  d_cache_tag_t            tag_arr_q [NUM_LINES];

  logic [INDEX_WIDTH-1:0]  idx;
  logic [OFFSET_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0]   req_tag;
  d_cache_tag_t            entry, tag_wentry;
  logic                    hit, tag_we;
  logic                    dwe;
  logic [LINE_SHIFT-1:0]   draddr, dwaddr;
  logic [DATA_WIDTH-1:0]   drdata, dwdata;
  logic                    unused_addr_next;

  assign unused_addr_next = ^i_in_addr_next;
  assign idx     = i_in_addr[LINE_SHIFT-1:OFFSET_WIDTH];
  assign off     = i_in_addr[OFFSET_WIDTH-1:0];
  assign req_tag = i_in_addr >> LINE_SHIFT;
  assign entry   = tag_arr_q[idx];
  assign hit     = entry.valid && (entry.tag == req_tag);

  d_cache_data_array #(.AW(LINE_SHIFT), .DW(DATA_WIDTH)) u_data (
    .clk  (clk),
    .raddr(draddr),
    .rdata(drdata),
    .we   (dwe),
    .waddr(dwaddr),
    .wdata(dwdata)
  );

  // Next-state, memory port and array write control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_valid  = 1'b0;
    out_data   = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    draddr     = {idx, off};
    dwe        = 1'b0;
    dwaddr     = {idx, off};
    dwdata     = i_in_data;
    tag_we     = 1'b0;
    tag_wentry = entry;
    case (state_q)
      IDLE: begin
        if (i_in_valid) begin
          if (hit) begin
            out_valid = 1'b1;
            out_data  = drdata;
            if (mem_action_t'(i_in_mem_action) == WRITE) begin
              dwe              = 1'b1;
              tag_we           = 1'b1;
              tag_wentry.dirty = 1'b1;
            end
          end else begin
            state_d = (entry.valid && entry.dirty) ? WRITEBACK : REFILL;
            cnt_d   = '0;
          end
        end
      end
      WRITEBACK: begin
        draddr    = {idx, cnt_q};
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = (entry.tag << LINE_SHIFT) | ADDR_WIDTH'({idx, cnt_q});
        mem_wdata = drdata;
        if (mem_ack) begin
          cnt_d = cnt_q + OFFSET_WIDTH'(1);
          if (cnt_q == '1) state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {i_in_addr[ADDR_WIDTH-1:OFFSET_WIDTH], cnt_q};
        if (mem_ack) begin
          dwe    = 1'b1;
          dwaddr = {idx, cnt_q};
          dwdata = mem_rdata;
          cnt_d  = cnt_q + OFFSET_WIDTH'(1);
          if (cnt_q == '1) begin
            tag_we     = 1'b1;
            tag_wentry = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < NUM_LINES; i++) tag_arr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (tag_we) tag_arr_q[idx] <= tag_wentry;
    end
  end

`ifdef D_CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  // Saturating hit/miss counters.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && i_in_valid && hit && hit_count_q != '1)
      hit_count_d = hit_count_q + 32'd1;
    if (state_q == IDLE && state_d != IDLE && miss_count_q != '1)
      miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_d_cache_lite.sv
// Scoreboard bench for d_cache_lite: flat architectural memory model plus line-state model.
module tb_d_cache_lite;
  import mips_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_in_valid = 1'b0, i_in_mem_action = 1'b0;
  logic [25:0] i_in_addr = '0, i_in_addr_next = '0;
  logic [31:0] i_in_data = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        mem_req, mem_we;
  logic [25:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef D_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  d_cache_lite dut (
    .clk(clk), .rst(rst),
    .i_in_valid(i_in_valid), .i_in_mem_action(i_in_mem_action),
    .i_in_addr(i_in_addr), .i_in_addr_next(i_in_addr_next), .i_in_data(i_in_data),
    .out_valid(out_valid), .out_data(out_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef D_CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    bit          hit;
    bit          wb;
    logic [25:0] vbase;
    logic [25:0] lbase;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] phys [logic [25:0]];
  logic [31:0] arch [logic [25:0]];
  bit          mvalid [16];
  bit          mdirty [16];
  logic [19:0] mtag   [16];
  int          n_chk = 0, n_pass = 0, n_acc = 0, n_miss = 0;
  int          ack_mode = 0;

  function automatic logic [31:0] phys_get(logic [25:0] a);
    if (phys.exists(a)) return phys[a];
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] arch_get(logic [25:0] a);
    if (arch.exists(a)) return arch[a];
    return phys_get(a);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end
    arch.delete();
    n_acc  = 0;
    n_miss = 0;
  endtask

  // Call at posedge+1: predicts the response, then presents the request.
  task automatic start(bit we, logic [25:0] a, logic [31:0] d);
    exp_t e;
    int   ix = int'(a[5:2]);
    e.is_rd = !we;
    e.hit   = mvalid[ix] && (mtag[ix] == a[25:6]);
    e.wb    = !e.hit && mvalid[ix] && mdirty[ix];
    e.vbase = {mtag[ix], a[5:2], 2'b00};
    e.lbase = {a[25:2], 2'b00};
    e.data  = arch_get(a);
    if (!e.hit) begin
      mvalid[ix] = 1'b1;
      mdirty[ix] = 1'b0;
      mtag[ix]   = a[25:6];
      n_miss++;
    end
    if (we) begin
      mdirty[ix] = 1'b1;
      arch[a]    = d;
    end
    expq.push_back(e);
    i_in_valid      = 1'b1;
    i_in_mem_action = we;
    i_in_addr       = a;
    i_in_addr_next  = a + 26'd1;
    i_in_data       = d;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 300);
    if (out_valid !== 1'b1) begin
      n_chk++;
      $display("FAIL timeout: no out_valid within %0d cycles", n);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic access(bit we, logic [25:0] a, logic [31:0] d);
    start(we, a, d);
    wait_done();
  endtask

  task automatic idle(int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory responder and monitor, sampled on the falling edge.
  int          tick = 0, cyc = 0, wbc = 0, rdc = 0, stalls = 0;
  bit          pend = 0;
  logic [25:0] paddr;
  logic        pwe;
  logic [31:0] pwd;
  initial begin
    exp_t e;
    bit   ack;
    forever begin
      @(negedge clk);
      tick++;
      if (rst) begin
        cyc = 0; wbc = 0; rdc = 0; stalls = 0; pend = 0;
        mem_ack = 1'b0;
        continue;
      end
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = (tick % 3 == 0);
        default: ack = 1'($urandom_range(0, 1));
      endcase
      mem_ack   = mem_req ? ack : 1'($urandom_range(0, 1));
      mem_rdata = (mem_req && !mem_we) ? phys_get(mem_addr) : $urandom;
      if (pend) begin
        chk("hold_req", 64'(mem_req), 64'd1);
        chk("hold_addr", 64'(mem_addr), 64'(paddr));
        chk("hold_we", 64'(mem_we), 64'(pwe));
        if (pwe) chk("hold_wdata", 64'(mem_wdata), 64'(pwd));
      end
      if (expq.size() == 0) begin
        chk("idle_req", 64'(mem_req), 64'd0);
        chk("idle_valid", 64'(out_valid), 64'd0);
      end else begin
        e = expq[0];
        if (mem_req && !mem_ack) stalls++;
        if (mem_req && mem_ack) begin
          if (e.wb && wbc < 4) begin
            chk("wb_we", 64'(mem_we), 64'd1);
            chk("wb_addr", 64'(mem_addr), 64'(e.vbase + 26'(wbc)));
            chk("wb_data", 64'(mem_wdata), 64'(arch_get(e.vbase + 26'(wbc))));
            wbc++;
          end else begin
            chk("rf_we", 64'(mem_we), 64'd0);
            chk("rf_addr", 64'(mem_addr), 64'(e.lbase + 26'(rdc)));
            rdc++;
          end
        end
        if (mem_req && mem_ack && mem_we) phys[mem_addr] = mem_wdata;
        if (out_valid) begin
          chk("wb_words", 64'(wbc), e.wb ? 64'd4 : 64'd0);
          chk("rf_words", 64'(rdc), e.hit ? 64'd0 : 64'd4);
          chk("latency", 64'(cyc), e.hit ? 64'd0 : 64'(1 + (e.wb ? 8 : 4) + stalls));
          if (e.is_rd) chk("rd_data", 64'(out_data), 64'(e.data));
          void'(expq.pop_front());
          n_acc++;
          cyc = 0; wbc = 0; rdc = 0; stalls = 0;
        end else begin
          cyc++;
        end
      end
      pend  = mem_req && !mem_ack;
      paddr = mem_addr;
      pwe   = mem_we;
      pwd   = mem_wdata;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) phys[26'h10 + 26'(i)] = 32'hA0 + 32'(i);
    model_reset();

    // Reset state, even with a request presented.
    i_in_valid = 1'b1;
    i_in_addr  = 26'h10;
    @(negedge clk);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    i_in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold fill, hit, write hit, dirty eviction.
    ack_mode = 0;
    access(1'b0, 26'h10, 32'h0);
    access(1'b0, 26'h13, 32'h0);
    access(1'b1, 26'h11, 32'hDEAD_BEEF);
    access(1'b0, 26'h51, 32'h0);
`ifdef D_CACHE_STATS_EN
    #1;
    chk("hit_count", 64'(hit_count), 64'(n_acc));
    chk("miss_count", 64'(miss_count), 64'(n_miss));
`endif

    // Slow memory: ack every third cycle.
    ack_mode = 1;
    access(1'b0, 26'h20, 32'h0);
    access(1'b0, 26'h23, 32'h0);

    // Reset during the second refill word.
    ack_mode = 0;
    start(1'b0, 26'h30, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_req", 64'(mem_req), 64'd1);
    rst        = 1'b1;
    i_in_valid = 1'b0;
    expq.delete();
    model_reset();
    #1;
    chk("mid_rst_req", 64'(mem_req), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    access(1'b0, 26'h30, 32'h0);

    // Back-to-back hits on one word.
    access(1'b0, 26'h12, 32'h0);
    access(1'b0, 26'h12, 32'h0);
    access(1'b1, 26'h12, 32'h55);
    access(1'b0, 26'h12, 32'h0);

    // Random traffic over 64 lines sharing 16 sets.
    ack_mode = 2;
    for (int n = 0; n < 250; n++) begin
      access(1'($urandom_range(0, 1)), 26'($urandom_range(0, 255)), $urandom);
      idle(int'($urandom_range(0, 2)));
    end
`ifdef D_CACHE_STATS_EN
    #1;
    chk("hit_count_end", 64'(hit_count), 64'(n_acc));
    chk("miss_count_end", 64'(miss_count), 64'(n_miss));
`endif
    idle(2);
    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
